// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//
// Responder side of the card-request interface used by the blackjack game FSM.
// Each draw request returns one card from a single 52-card deck, with no card
// repeated until the deck is reshuffled. The starting position of every draw
// comes from a free-running 16-bit LFSR. A "dealt" bitmap records which cards
// have left the deck. The probe walks forward from that start, wrapping at the
// end of the deck, until it finds a card that is still in the deck.
//
// Card index idx (0..51) maps to value = idx % 13 + 1 (1=Ace .. 13=King) and
// symbol = idx / 13 (suit 0..3). Value 0 with symbol 0 means "no card". That
// pair is returned when a draw is requested from an empty deck.
//
// Ports:
//   clk          system clock, rising edge active
//   rst          synchronous reset, active-high
//   shuffle      return all 52 cards to the deck; aborts any draw in progress
//   req          draw request, sampled only while idle
//   ack          one-cycle pulse: card_value / card_symbol are valid
//   card_value   registered card value (holds until the next grant or reset)
//   card_symbol  registered card suit  (holds until the next grant or reset)
//   busy         high while a draw is in progress (any state but IDLE)
//   deck_empty   high when no cards are left in the deck
//   cards_left   number of undealt cards, 0..52
// -----------------------------------------------------------------------------
module card_dealer #(
  parameter logic [15:0] SEED = 16'hACE1  // LFSR load value; must be non-zero
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       req,
  output logic       ack,
  output logic [3:0] card_value,
  output logic [1:0] card_symbol,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  localparam logic [5:0] DECK_SIZE = 6'd52;
  localparam logic [5:0] LAST_IDX  = 6'd51;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [51:0] dealt;        // one bit per card, 1 = card has left the deck
  logic [5:0]  ptr;          // card index currently being probed
  logic [5:0]  start;        // LFSR-derived starting index, folded into 0..51
  logic [5:0]  ptr_wrapped;  // ptr + 1 with wrap from 51 back to 0

  // Strobes from the control FSM to the datapath.
  logic        load_ptr;     // begin a draw at the LFSR start index
  logic        step_ptr;     // card at ptr already dealt, try the next one
  logic        take_card;    // card at ptr is free: deal it and present it
  logic        grant_empty;  // draw on an empty deck: present "no card"
  logic        clear_deck;   // shuffle: every card back in the deck

  // Index to value/suit decode for the card at ptr.
  logic [1:0]  ptr_symbol;
  logic [5:0]  ptr_base;
  logic [3:0]  ptr_value;

  // ---------------------------------------------------------------------------
  // LFSR: Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  // The taps at polynomial degrees 16/14/13/11 are bits 0/2/3/5.
  // ---------------------------------------------------------------------------
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Six LFSR bits cover 0..63. The values 52..63 fold back onto 0..11.
  // The start is slightly biased as a result, but the deck still never
  // repeats a card.
  assign start = (lfsr[5:0] >= DECK_SIZE) ? (lfsr[5:0] - DECK_SIZE) : lfsr[5:0];

  assign ptr_wrapped = (ptr == LAST_IDX) ? 6'd0 : (ptr + 6'd1);

  always_comb begin
    ptr_symbol = 2'd0;
    ptr_base   = 6'd0;
    if (ptr >= 6'd39) begin
      ptr_symbol = 2'd3;
      ptr_base   = 6'd39;
    end else if (ptr >= 6'd26) begin
      ptr_symbol = 2'd2;
      ptr_base   = 6'd26;
    end else if (ptr >= 6'd13) begin
      ptr_symbol = 2'd1;
      ptr_base   = 6'd13;
    end
    ptr_value = 4'(ptr - ptr_base + 6'd1);
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and datapath strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path can leave one unassigned and infer a latch.
    state_next  = state;
    load_ptr    = 1'b0;
    step_ptr    = 1'b0;
    take_card   = 1'b0;
    grant_empty = 1'b0;
    clear_deck  = 1'b0;

    if (shuffle) begin
      // Shuffle overrides everything below it. A draw in flight is dropped
      // without an ack, and a req in the same cycle is ignored.
      clear_deck = 1'b1;
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (cards_left != 6'd0) begin
              load_ptr   = 1'b1;
              state_next = PROBE;
            end else begin
              grant_empty = 1'b1;
              state_next  = GRANT;
            end
          end
        end
        PROBE: begin
          if (!dealt[ptr]) begin
            take_card  = 1'b1;
            state_next = GRANT;
          end else begin
            step_ptr = 1'b1;
          end
        end
        GRANT: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    // All flops then sample their inputs together at the clock edge.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: LFSR, dealt bitmap, card counter, probe pointer, card outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= SEED;
      // NOTE: the bitmap is plain flops, not a RAM. This lets reset and
      // shuffle clear all 52 bits in a single cycle.
      dealt       <= '0;
      cards_left  <= DECK_SIZE;
      ptr         <= 6'd0;
      card_value  <= 4'd0;
      card_symbol <= 2'd0;
    end else begin
      // The LFSR runs in every state. The draw start therefore depends on
      // the exact cycle of the request.
      lfsr <= {lfsr_fb, lfsr[15:1]};

      if (clear_deck) begin
        dealt      <= '0;
        cards_left <= DECK_SIZE;
      end

      if (load_ptr) begin
        ptr <= start;
      end

      if (step_ptr) begin
        ptr <= ptr_wrapped;
      end

      // The card registers are loaded on the way into GRANT. This makes them
      // valid during the ack cycle, and they hold that value until the next
      // grant.
      if (take_card) begin
        dealt[ptr]  <= 1'b1;
        cards_left  <= cards_left - 6'd1;
        card_value  <= ptr_value;
        card_symbol <= ptr_symbol;
      end

      if (grant_empty) begin
        card_value  <= 4'd0;
        card_symbol <= 2'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs.
  // ---------------------------------------------------------------------------
  assign ack        = (state == GRANT);
  assign busy       = (state != IDLE);
  assign deck_empty = (cards_left == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
//
// Self-checking bench for card_dealer. A deck model (an array of dealt flags
// plus a card count) predicts every draw. The model picks the first undealt
// card at or after the LFSR start, wrapping at 52. It also predicts the ack
// latency, which is 2 cycles plus one cycle per skipped card, or 1 cycle on
// an empty deck. A cycle-by-cycle table covers the control corners: reset,
// shuffle, shuffle with req, shuffle during a probe, and req while busy.
// -----------------------------------------------------------------------------
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       shuffle;
  logic       req;
  logic       ack;
  logic [3:0] card_value;
  logic [1:0] card_symbol;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  card_dealer #(.SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .shuffle    (shuffle),
    .req        (req),
    .ack        (ack),
    .card_value (card_value),
    .card_symbol(card_symbol),
    .busy       (busy),
    .deck_empty (deck_empty),
    .cards_left (cards_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // LFSR x^16+x^14+x^13+x^11+1. The new top bit is the XOR of bits 0,2,3,5.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    int b;
    b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return (x >> 1) | 16'(b << 15);
  endfunction

  // m_lfsr tracks the LFSR value that is in effect during the current cycle.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int start_of(input logic [15:0] l);
    int r;
    r = int'(l) % 64;
    return (r >= 52) ? r - 52 : r;
  endfunction

  bit m_dealt[52];
  int m_left;

  task automatic model_reset();
    for (int i = 0; i < 52; i++) m_dealt[i] = 1'b0;
    m_left = 52;
  endtask

  task automatic model_pick(input int st, output int idx, output int skips);
    idx   = -1;
    skips = 0;
    for (int k = 0; k < 52; k++) begin
      int i;
      i = (st + k) % 52;
      if (!m_dealt[i]) begin
        idx   = i;
        skips = k;
        break;
      end
    end
  endtask

  // Issue one draw. The caller must be at a negedge with the DUT in IDLE.
  // With hold=1, req stays high for a back-to-back draw.
  task automatic draw(input bit hold, input string tag);
    int exp_lat, ev, es, idx, skips, n;
    bit got;
    req = 1'b1;
    if (m_left == 0) begin
      exp_lat = 1;
      ev      = 0;
      es      = 0;
    end else begin
      model_pick(start_of(m_lfsr), idx, skips);
      exp_lat = 2 + skips;
      ev      = idx % 13 + 1;
      es      = idx / 13;
      m_dealt[idx] = 1'b1;
      m_left--;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (!hold) req = 1'b0;
      if (ack) got = 1'b1;
    end
    check($sformatf("%s_latency", tag), n, exp_lat);
    if (got) begin
      check($sformatf("%s_value", tag), card_value, ev);
      check($sformatf("%s_symbol", tag), card_symbol, es);
      check($sformatf("%s_cards_left", tag), cards_left, m_left);
    end
  endtask

  task automatic do_shuffle(input string tag);
    logic [3:0] v;
    logic [1:0] s;
    v = card_value;
    s = card_symbol;
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    model_reset();
    check($sformatf("%s_cards_left", tag), cards_left, 52);
    check($sformatf("%s_deck_empty", tag), deck_empty, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_value_held", tag), card_value, v);
    check($sformatf("%s_symbol_held", tag), card_symbol, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_cards_left", tag), cards_left, 52);
    check($sformatf("%s_deck_empty", tag), deck_empty, 0);
    check($sformatf("%s_ack", tag), ack, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_value", tag), card_value, 0);
    check($sformatf("%s_symbol", tag), card_symbol, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Cycle table: inputs applied at a negedge, results checked one cycle later.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit rst;
    bit shuffle;
    bit req;
    bit exp_busy;
    bit exp_ack;
    int exp_left;
    bit chk_zero_card;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit seen[4][16];
    int distinct;
    int rem, target, d;
    logic [15:0] l;

    // rst shuffle req | busy ack left zero_card
    tbl[0]  = '{1, 0, 0, 0, 0, 52, 1};  // reset
    tbl[1]  = '{0, 0, 1, 1, 0, 52, 0};  // req -> PROBE
    tbl[2]  = '{0, 0, 0, 1, 1, 51, 0};  // full deck: first probe hits -> GRANT
    tbl[3]  = '{0, 0, 0, 0, 0, 51, 0};  // back to IDLE, ack was one cycle
    tbl[4]  = '{0, 1, 0, 0, 0, 52, 0};  // shuffle in IDLE
    tbl[5]  = '{0, 1, 1, 0, 0, 52, 0};  // shuffle + req: req dropped
    tbl[6]  = '{0, 0, 1, 1, 0, 52, 0};  // req -> PROBE
    tbl[7]  = '{0, 1, 0, 0, 0, 52, 0};  // shuffle during PROBE: aborted
    tbl[8]  = '{0, 0, 1, 1, 0, 52, 0};  // req -> PROBE
    tbl[9]  = '{0, 0, 1, 1, 1, 51, 0};  // req while busy ignored; GRANT
    tbl[10] = '{0, 0, 0, 0, 0, 51, 0};  // IDLE, nothing queued
    tbl[11] = '{1, 0, 0, 0, 0, 52, 1};  // reset clears deck and card

    rst     = 1'b1;
    shuffle = 1'b0;
    req     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single draw right after reset.
    draw(1'b0, "first");

    // Full deck dealt back to back with req held high.
    do_shuffle("shuffle1");
    distinct = 0;
    for (int i = 0; i < 52; i++) begin
      if (i > 0) @(negedge clk);
      draw(1'b1, $sformatf("b2b%0d", i));
      if (card_value >= 1 && card_value <= 13 && !seen[card_symbol][card_value]) begin
        seen[card_symbol][card_value] = 1'b1;
        distinct++;
      end
    end
    check("b2b_distinct", distinct, 52);
    check("b2b_cards_left", cards_left, 0);
    check("b2b_deck_empty", deck_empty, 1);
    @(negedge clk);
    draw(1'b0, "empty");
    check("empty_deck_empty", deck_empty, 1);

    // Randomly spaced draws down to one card left.
    do_shuffle("shuffle2");
    for (int i = 0; i < 51; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      draw(1'b0, $sformatf("rnd%0d", i));
    end

    // Last card: wait until the start falls just past the remaining card.
    // The probe then has to walk the whole deck (and wrap 51->0 if needed).
    rem = 0;
    for (int i = 0; i < 52; i++) if (!m_dealt[i]) rem = i;
    target = (rem + 1) % 52;
    @(negedge clk);
    l = m_lfsr;
    d = 0;
    while (start_of(l) != target && d < 20000) begin
      l = lfsr_next(l);
      d++;
    end
    repeat (d) @(negedge clk);
    draw(1'b0, "wrap");
    check("wrap_deck_empty", deck_empty, 1);
    do_shuffle("shuffle3");

    // Control corners from the table.
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rst     = tbl[i].rst;
      shuffle = tbl[i].shuffle;
      req     = tbl[i].req;
      @(negedge clk);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("tbl%0d_ack", i), ack, tbl[i].exp_ack);
      check($sformatf("tbl%0d_cards_left", i), cards_left, tbl[i].exp_left);
      check($sformatf("tbl%0d_deck_empty", i), deck_empty, tbl[i].exp_left == 0);
      if (tbl[i].chk_zero_card) begin
        check($sformatf("tbl%0d_value", i), card_value, 0);
        check($sformatf("tbl%0d_symbol", i), card_symbol, 0);
      end
    end
    rst     = 1'b0;
    shuffle = 1'b0;
    req     = 1'b0;
    model_reset();

    // Draw a few cards, then reset in the middle of a probe.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      draw(1'b0, $sformatf("pre%0d", i));
    end
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("midprobe_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("midprobe_rst");

    // The LFSR reloads SEED on reset, so the model must match again.
    draw(1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
